// File: rtl/seq_fixed_multiplier_pkg.sv
// Shared types and range-bound helpers for the sequential fixed-point multiplier.
// Exports the FSM state enum and the signed/unsigned bound functions.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Widest operand the bound helpers support; callers truncate.
    localparam int MAX_W = 256;

    function automatic logic [MAX_W-1:0] umax_f(input int w);
        return (MAX_W'(1) << w) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] smax_f(input int w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] smin_f(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/seq_fixed_multiplier_if.sv
// Operand/result handshake bundle for seq_fixed_multiplier.
// master: producer/consumer side; slave: the multiplier.
interface seq_fixed_multiplier_if #(
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     result;
    logic [2*WIDTH-1:0]   product_full;
    logic                 overflow;
    logic [CW-1:0]        busy_count;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, result, product_full,
        input  overflow, busy_count
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, result, product_full,
        output overflow, busy_count
    );

endinterface

// File: rtl/seq_fixed_multiplier_adder.sv
// W-bit combinational adder with carry-out (accumulator adder).
// Ports: x, y addends; sum W-bit sum; cout carry-out.
module adder_w #(
    parameter int W = 64
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, x} + {1'b0, y};
endmodule

// File: rtl/seq_fixed_multiplier.sv
// Radix-2 shift-add multiplier with Q-format scaling and optional saturation.
// Ports: clock, reset (sync, active-high), bus (operand/result handshake).
module seq_fixed_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 0,
    parameter int SATURATE  = 1
) (
    input logic                  clock,
    input logic                  reset,
    seq_fixed_multiplier_if.slave bus
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] S_MAX = WIDTH'(smax_f(WIDTH));
    localparam logic [WIDTH-1:0] S_MIN = WIDTH'(smin_f(WIDTH));
    localparam logic [WIDTH-1:0] U_MAX = WIDTH'(umax_f(WIDTH));

    mult_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W2-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              sm_q, sm_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [W2-1:0]     product_q, product_d;
    logic              ovf_q, ovf_d;

    logic [W2-1:0]        addend;
    logic [W2-1:0]        sum;
    logic                 add_cout_unused;
    logic [W2-1:0]        prod;
    logic signed [W2-1:0] scaled_s;
    logic [W2-1:0]        scaled_u;
    logic [W2-WIDTH:0]    ext;
    logic                 fin_ovf;
    logic [WIDTH-1:0]     fin_res;

    function automatic logic [WIDTH-1:0] mag(
        input logic [WIDTH-1:0] v,
        input logic             sm
    );
        return (sm && v[WIDTH-1]) ? -v : v;
    endfunction

    // Multiplier shifts right, multiplicand left: bit 0 of the
    // multiplier is always magA[busy_count].
    assign addend = mplier_q[0] ? mcand_q : '0;

    adder_w #(.W(W2)) u_add (
        .x    (acc_q),
        .y    (addend),
        .sum  (sum),
        .cout (add_cout_unused)
    );

    always_comb begin
        prod     = neg_q ? -sum : sum;
        scaled_s = $signed(prod) >>> FRAC_BITS;
        scaled_u = prod >> FRAC_BITS;
        // Signed fits iff the bits above the result MSB are a sign extension.
        ext      = scaled_s[W2-1:WIDTH-1];
        fin_ovf  = sm_q ? ((|ext) && !(&ext)) : (|scaled_u[W2-1:WIDTH]);
        fin_res  = sm_q ? scaled_s[WIDTH-1:0] : scaled_u[WIDTH-1:0];
        if (fin_ovf && SATURATE != 0) begin
            fin_res = sm_q ? (scaled_s[W2-1] ? S_MIN : S_MAX) : U_MAX;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        sm_d      = sm_q;
        result_d  = result_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mplier_d = mag(bus.a, bus.signed_mode);
                    mcand_d  = {{WIDTH{1'b0}}, mag(bus.b, bus.signed_mode)};
                    neg_d    = bus.signed_mode &
                               (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    sm_d     = bus.signed_mode;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    product_d = prod;
                    result_d  = fin_res;
                    ovf_d     = fin_ovf;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            sm_q      <= 1'b0;
            result_q  <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            sm_q      <= sm_d;
            result_q  <= result_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.out_valid    = (state_q == DONE);
    assign bus.result       = result_q;
    assign bus.product_full = product_q;
    assign bus.overflow     = ovf_q;
    assign bus.busy_count   = cnt_q;

endmodule

// File: tb/tb_seq_fixed_multiplier.sv
// Bench for seq_fixed_multiplier: three configurations run in lockstep
// (Q0 saturating, Q0 wrapping, Q16 saturating) against an arithmetic model.
module tb_seq_fixed_multiplier;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sm_drv = 1'b0;
    logic [31:0] a_drv = '0;
    logic [31:0] b_drv = '0;

    int total  = 0;
    int passed = 0;

    always #5 clock = ~clock;

    seq_fixed_multiplier_if #(.WIDTH(32)) if0 ();
    seq_fixed_multiplier_if #(.WIDTH(32)) if1 ();
    seq_fixed_multiplier_if #(.WIDTH(32)) if2 ();

    assign if0.in_valid = in_valid;
    assign if0.a = a_drv;
    assign if0.b = b_drv;
    assign if0.signed_mode = sm_drv;
    assign if0.out_ready = out_ready;
    assign if1.in_valid = in_valid;
    assign if1.a = a_drv;
    assign if1.b = b_drv;
    assign if1.signed_mode = sm_drv;
    assign if1.out_ready = out_ready;
    assign if2.in_valid = in_valid;
    assign if2.a = a_drv;
    assign if2.b = b_drv;
    assign if2.signed_mode = sm_drv;
    assign if2.out_ready = out_ready;

    seq_fixed_multiplier #(.WIDTH(32), .FRAC_BITS(0), .SATURATE(1)) u0 (
        .clock (clock), .reset (reset), .bus (if0.slave));
    seq_fixed_multiplier #(.WIDTH(32), .FRAC_BITS(0), .SATURATE(0)) u1 (
        .clock (clock), .reset (reset), .bus (if1.slave));
    seq_fixed_multiplier #(.WIDTH(32), .FRAC_BITS(16), .SATURATE(1)) u2 (
        .clock (clock), .reset (reset), .bus (if2.slave));

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: exact product via 64-bit arithmetic, then shift and range check.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         input logic sm, input int frac, input int sat,
                         output logic [31:0] res, output logic [63:0] pf,
                         output logic ov);
        longint      sp;
        longint      sc;
        logic [63:0] up;
        logic [63:0] uc;
        if (sm) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            pf = sp;
            sc = sp >>> frac;
            ov = 1'b0;
            res = sc[31:0];
            if (sc > 64'sd2147483647) begin
                ov = 1'b1;
                if (sat != 0) res = 32'h7FFF_FFFF;
            end else if (sc < -64'sd2147483648) begin
                ov = 1'b1;
                if (sat != 0) res = 32'h8000_0000;
            end
        end else begin
            up = {32'b0, a} * {32'b0, b};
            pf = up;
            uc = up >> frac;
            ov = (uc > 64'h0000_0000_FFFF_FFFF);
            res = uc[31:0];
            if (ov && sat != 0) res = 32'hFFFF_FFFF;
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic sm, input string tag);
        int n = 0;
        while (!if0.in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_ready_wait"}, 64'(if0.in_ready), 64'd1);
        a_drv = a;
        b_drv = b;
        sm_drv = sm;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        // Operands must be ignored after acceptance.
        a_drv = $urandom;
        b_drv = $urandom;
        sm_drv = ~sm;
        chk({tag, "_in_ready_fall"}, 64'(if0.in_ready), 64'd0);
    endtask

    task automatic finish_op(input logic [31:0] a, input logic [31:0] b,
                             input logic sm, input string tag);
        int          n = 0;
        logic [31:0] r;
        logic [63:0] p;
        logic        o;
        while (!if0.out_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd32);
        model(a, b, sm, 0, 1, r, p, o);
        chk({tag, "_res_sat"}, 64'(if0.result), 64'(r));
        chk({tag, "_pf_sat"}, if0.product_full, p);
        chk({tag, "_ov_sat"}, 64'(if0.overflow), 64'(o));
        model(a, b, sm, 0, 0, r, p, o);
        chk({tag, "_res_wrap"}, 64'(if1.result), 64'(r));
        chk({tag, "_ov_wrap"}, 64'(if1.overflow), 64'(o));
        model(a, b, sm, 16, 1, r, p, o);
        chk({tag, "_res_q16"}, 64'(if2.result), 64'(r));
        chk({tag, "_pf_q16"}, if2.product_full, p);
        chk({tag, "_ov_q16"}, 64'(if2.overflow), 64'(o));
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic sm, input string tag);
        start_op(a, b, sm, tag);
        finish_op(a, b, sm, tag);
        @(negedge clock);
        chk({tag, "_ovalid_drop"}, 64'(if0.out_valid), 64'd0);
        chk({tag, "_iready_back"}, 64'(if0.in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        int          n;

        repeat (2) @(negedge clock);
        chk("rst_in_ready", 64'(if0.in_ready), 64'd1);
        chk("rst_out_valid", 64'(if0.out_valid), 64'd0);
        chk("rst_result", 64'(if0.result), 64'd0);
        chk("rst_pf", if0.product_full, 64'd0);
        chk("rst_ov", 64'(if0.overflow), 64'd0);
        chk("rst_cnt", 64'(if0.busy_count), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        run_op(32'd8, 32'd2, 1'b0, "u8x2");

        start_op(32'hFFFF_FFFD, 32'd7, 1'b1, "sm3x7");
        finish_op(32'hFFFF_FFFD, 32'd7, 1'b1, "sm3x7");
        chk("sm3x7_lit_res", 64'(if0.result), 64'h0000_0000_FFFF_FFEB);
        chk("sm3x7_lit_pf", if0.product_full, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clock);

        start_op(32'hFFFF_FFFD, 32'd7, 1'b0, "um3x7");
        finish_op(32'hFFFF_FFFD, 32'd7, 1'b0, "um3x7");
        chk("um3x7_lit_pf", if0.product_full, 64'h0000_0006_FFFF_FFEB);
        chk("um3x7_lit_wrap", 64'(if1.result), 64'h0000_0000_FFFF_FFEB);
        chk("um3x7_lit_ov", 64'(if1.overflow), 64'd1);
        @(negedge clock);

        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "minx1");
        finish_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "minx1");
        chk("minx1_lit_sat", 64'(if0.result), 64'h0000_0000_7FFF_FFFF);
        chk("minx1_lit_wrap", 64'(if1.result), 64'h0000_0000_8000_0000);
        @(negedge clock);

        start_op(32'h0001_8000, 32'hFFFE_0000, 1'b1, "q16");
        finish_op(32'h0001_8000, 32'hFFFE_0000, 1'b1, "q16");
        chk("q16_lit_res", 64'(if2.result), 64'h0000_0000_FFFD_0000);
        chk("q16_lit_ov", 64'(if2.overflow), 64'd0);
        @(negedge clock);

        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, "minxmin");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "maxxmax");
        run_op(32'd0, 32'hDEAD_BEEF, 1'b1, "zero");

        // Backpressure: result held while consumer stalls.
        out_ready = 1'b0;
        ra = $urandom;
        rb = $urandom;
        start_op(ra, rb, 1'b1, "bp");
        finish_op(ra, rb, 1'b1, "bp");
        held = if0.result;
        for (int i = 0; i < 10; i++) begin
            a_drv = $urandom;
            b_drv = $urandom;
            in_valid = 1'b1;
            @(negedge clock);
            chk("bp_hold_res", 64'(if0.result), 64'(held));
            chk("bp_hold_iready", 64'(if0.in_ready), 64'd0);
            chk("bp_hold_ovalid", 64'(if0.out_valid), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk("bp_release_ovalid", 64'(if0.out_valid), 64'd0);
        chk("bp_release_iready", 64'(if0.in_ready), 64'd1);
        run_op($urandom, $urandom, 1'b0, "bp_next");

        // Reset mid-operation.
        start_op(32'd1234, 32'd5678, 1'b0, "rstmid");
        n = 0;
        while (if0.busy_count != 6'd10 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("rstmid_reach10", 64'(if0.busy_count), 64'd10);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rstmid_iready", 64'(if0.in_ready), 64'd1);
        chk("rstmid_ovalid", 64'(if0.out_valid), 64'd0);
        chk("rstmid_res", 64'(if0.result), 64'd0);
        chk("rstmid_pf", if0.product_full, 64'd0);
        chk("rstmid_ov", 64'(if0.overflow), 64'd0);
        chk("rstmid_cnt", 64'(if0.busy_count), 64'd0);
        run_op(32'd5, 32'd5, 1'b0, "five");
        chk("five_lit", 64'(if0.result), 64'd25);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 1) ra = ra >> $urandom_range(31, 8);
            if (i % 4 == 2) rb = rb >> $urandom_range(31, 12);
            run_op(ra, rb, 1'($urandom_range(1, 0)), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
